// File: rtl/z_result_stage_pkg.sv
// Shared datapath definitions for the Z result stage: ALU op codes,
// result-stage FSM state encoding and the wide-op classifier.
package z_result_stage_pkg;

    // Full 5-bit ALU operation code space used by the datapath.
    typedef enum logic [4:0] {
        OP_NOP  = 5'b00000,
        OP_AND  = 5'b00001,
        OP_OR   = 5'b00010,
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_XOR  = 5'b00101,
        OP_NOT  = 5'b00110,
        OP_NEG  = 5'b00111,
        OP_SHL  = 5'b01000,
        OP_SHR  = 5'b01001,
        OP_SHRA = 5'b01010,
        OP_ROL  = 5'b01011,
        OP_ROR  = 5'b01100,
        OP_SLT  = 5'b01101,
        OP_SLTU = 5'b01110,
        OP_MUL  = 5'b01111,
        OP_DIV  = 5'b10000
    } alu_op_t;

    // Result-stage FSM states.
    typedef enum logic [1:0] {
        Z_IDLE = 2'd0,
        Z_LO   = 2'd1,
        Z_HI   = 2'd2
    } z_state_t;

    // Plain-vector aliases of the state encoding for legacy-style FSM code.
    localparam logic [1:0] ST_IDLE = Z_IDLE;
    localparam logic [1:0] ST_LO   = Z_LO;
    localparam logic [1:0] ST_HI   = Z_HI;

    // MUL and DIV produce a full 64-bit result (two bus beats, LO/HI update).
    function automatic logic is_wide_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/z_result_stage_if.sv
// Handshake bundle between ALU, Z result stage and internal bus.
// master = ALU/bus side, slave = result stage.
interface z_result_stage_if #(parameter int DATA_W = 32);
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            op;
    logic [2*DATA_W-1:0]   alu_c;
    logic                  bus_valid;
    logic                  bus_ready;
    logic [DATA_W-1:0]     bus_out;
    logic                  bus_sel;

    modport master (
        output in_valid, op, alu_c, bus_ready,
        input  in_ready, bus_valid, bus_out, bus_sel
    );

    modport slave (
        input  in_valid, op, alu_c, bus_ready,
        output in_ready, bus_valid, bus_out, bus_sel
    );
endinterface

// File: rtl/z_result_stage_beat_mux.sv
// Beat selector: picks the Z half driven onto the bus for the current state.
// Outputs depend only on registered state and Z, so they behave as registers.
module z_beat_mux
    import z_result_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] z,
    input  logic [1:0]          state,
    output logic [DATA_W-1:0]   bus_out,
    output logic                bus_sel
);

    // Drive the low word in LO, the high word in HI and zero while idle.
    always_comb begin
        bus_out = '0;
        bus_sel = 1'b0;
        if (state == ST_LO) begin
            bus_out = z[DATA_W-1:0];
        end else if (state == ST_HI) begin
            bus_out = z[2*DATA_W-1:DATA_W];
            bus_sel = 1'b1;
        end
    end

endmodule

// File: rtl/z_result_stage.sv
// Z result stage: captures the ALU result, streams it as ZLO (and ZHI for
// MUL/DIV) beats onto the internal bus and updates LO/HI for wide ops.
// Optional feature macro: Z_FLAGS_EN (registered zero/negative flags).
//
// state | meaning
// IDLE  | no beat pending, ready for a new result
// LO    | ZLO beat on the bus
// HI    | ZHI beat on the bus (wide ops only)
module z_result_stage
    import z_result_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    z_result_stage_if.slave     zif,
    output logic [DATA_W-1:0]   lo_q,
    output logic [DATA_W-1:0]   hi_q,
    output logic                z_zero,
    output logic                z_neg
);

    logic [1:0]          state_q, state_d;
    logic [2*DATA_W-1:0] z_q, z_d;
    logic                wide_q, wide_d;
    logic [DATA_W-1:0]   lo_d, hi_d;
    logic                final_beat;
    logic                bus_fire;
    logic                in_fire;
    logic                in_ready;
    logic                bus_valid;
    logic [DATA_W-1:0]   bus_out;
    logic                bus_sel;

    // Handshake qualifiers; in_ready also opens when the last beat leaves.
    always_comb begin
        bus_valid  = (state_q != ST_IDLE);
        final_beat = ((state_q == ST_LO) && !wide_q) || (state_q == ST_HI);
        bus_fire   = bus_valid && zif.bus_ready;
        in_ready   = (state_q == ST_IDLE) || (final_beat && zif.bus_ready);
        in_fire    = zif.in_valid && in_ready;
    end

    // Next-state logic; a same-cycle input transfer overrides a return to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_fire) state_d = ST_LO;
            ST_LO: begin
                if (bus_fire) begin
                    if (wide_q)       state_d = ST_HI;
                    else if (in_fire) state_d = ST_LO;
                    else              state_d = ST_IDLE;
                end
            end
            ST_HI: begin
                if (bus_fire) state_d = in_fire ? ST_LO : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture Z and, for wide ops, the architectural LO/HI words.
    always_comb begin
        z_d    = z_q;
        wide_d = wide_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        if (in_fire) begin
            z_d    = zif.alu_c;
            wide_d = is_wide_op(zif.op);
            if (is_wide_op(zif.op)) begin
                lo_d = zif.alu_c[DATA_W-1:0];
                hi_d = zif.alu_c[2*DATA_W-1:DATA_W];
            end
        end
    end

    // State and data registers; reset discards any pending result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            z_q     <= '0;
            wide_q  <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
            wide_q  <= wide_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

`ifdef Z_FLAGS_EN
    logic zero_q, zero_d;
    logic neg_q, neg_d;

    // Flags follow the full product for MUL, otherwise the low word (DIV quotient).
    always_comb begin
        zero_d = zero_q;
        neg_d  = neg_q;
        if (in_fire) begin
            if (zif.op == OP_MUL) begin
                zero_d = (zif.alu_c == '0);
                neg_d  = zif.alu_c[2*DATA_W-1];
            end else begin
                zero_d = (zif.alu_c[DATA_W-1:0] == '0);
                neg_d  = zif.alu_c[DATA_W-1];
            end
        end
    end

    // Flag registers hold until the next accepted result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign z_zero = zero_q;
    assign z_neg  = neg_q;
`else
    assign z_zero = 1'b0;
    assign z_neg  = 1'b0;
`endif

    z_beat_mux #(.DATA_W(DATA_W)) u_beat_mux (
        .z       (z_q),
        .state   (state_q),
        .bus_out (bus_out),
        .bus_sel (bus_sel)
    );

    assign zif.in_ready  = in_ready;
    assign zif.bus_valid = bus_valid;
    assign zif.bus_out   = bus_out;
    assign zif.bus_sel   = bus_sel;

endmodule

// File: doc/z_result_stage.md
# z_result_stage

Result stage directly downstream of the datapath ALU. Captures the ALU's 64-bit result with its operation code, holds it in the Z register and streams it onto the 32-bit internal bus. Single-word results go out as one beat (ZLO). MUL and DIV results go out as two beats (ZLO, then ZHI) and also update the architectural LO/HI registers.

## Interface
- DATA_W, 32: bus word width; Z register is 2*DATA_W.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result and op are valid this cycle.
- in_ready  out  1  stage can accept a result this cycle.
- op  in  5  ALU operation code; OP_MUL = 5'b01111, OP_DIV = 5'b10000.
- alu_c  in  2*DATA_W  ALU result C. For DIV: low word is the quotient, high word is the remainder.
- bus_valid  out  1  bus_out holds a beat.
- bus_ready  in  1  consumer takes the beat this cycle.
- bus_out  out  DATA_W  beat data.
- bus_sel  out  1  0 = ZLO beat, 1 = ZHI beat.
- lo_q, hi_q  out  DATA_W  LO/HI architectural registers.
- z_zero, z_neg  out  1  result flags (see Configuration).

## Operation
- Transfers: input transfer when in_valid && in_ready; bus transfer when bus_valid && bus_ready.
- Wide ops: op equal to OP_MUL or OP_DIV. Every other op is narrow, and alu_c[63:32] is ignored for it.
- FSM states:
  - IDLE: bus_valid = 0.
  - LO: bus_out = z[31:0], bus_sel = 0, bus_valid = 1.
  - HI: bus_out = z[63:32], bus_sel = 1, bus_valid = 1.
- Transitions:
  - IDLE → LO on an input transfer.
  - LO → HI on a bus transfer if the captured op is wide.
  - LO → IDLE on a bus transfer if the captured op is narrow.
  - HI → IDLE on a bus transfer.
  - Exception to the two →IDLE cases: if a new input transfer occurs in the same cycle, the next state is LO with the new data.
- in_ready = (state == IDLE) || final beat transferring this cycle. The final beat is LO for narrow ops, HI for wide ops.
- On an input transfer: z ← alu_c and the wide flag ← is_wide(op). For wide ops only, lo_q ← alu_c[31:0] and hi_q ← alu_c[63:32] in the same edge.
- bus_out, bus_sel and bus_valid are stable while bus_valid = 1 && !bus_ready (no beat retraction or change).
- Reset values: state IDLE, z = 0, lo_q = 0, hi_q = 0, bus_valid = 0, bus_out = 0, bus_sel = 0, z_zero = 0, z_neg = 0. in_ready = 1 during and after reset.
- Reset mid-beat aborts the beat. The pending result is discarded; lo_q/hi_q return to 0.

## Timing
- Accept in cycle N → first beat valid in cycle N+1 (1-cycle latency). All outputs are registered except in_ready.
- Throughput with bus_ready held at 1:
  - narrow results: 1 per cycle (back-to-back through LO);
  - wide results: 1 per 2 cycles.
- A beat stalls indefinitely while bus_ready = 0. There is no timeout.
- lo_q/hi_q are visible in cycle N+1, before the ZHI beat is emitted.

## Configuration
- Z_FLAGS_EN defined: z_zero and z_neg are registered at input transfer.
  - Narrow ops: zero = (alu_c[31:0] == 0), neg = alu_c[31].
  - MUL: zero = (alu_c == 0), neg = alu_c[63].
  - DIV: flags are taken from the quotient word (alu_c[31:0]).
  - Flags hold until the next input transfer.
- Z_FLAGS_EN undefined: z_zero and z_neg are tied to 0 and no flag logic is synthesized.

## Structure
- Shared datapath package holds:
  - the ALU operation-code constants (the full 5-bit op enumeration, including OP_MUL and OP_DIV);
  - the z_state_t enum (IDLE/LO/HI);
  - an is_wide_op() function.
- One sub-module: z_beat_mux, which selects bus_out/bus_sel from z and state. Everything else is inline.

## Test plan
- ADD: op = 5'b00011, alu_c = 64'h0000_0000_0000_0007, bus_ready = 1 → one beat, bus_out = 32'h7, bus_sel = 0. lo_q/hi_q stay 0; z_zero = 0.
- MUL: op = OP_MUL, alu_c = 64'hFFFF_FFFF_FFFF_FFFA (−2 × 3) → beats 32'hFFFF_FFFA (sel 0), then 32'hFFFF_FFFF (sel 1). lo_q = FFFF_FFFA, hi_q = FFFF_FFFF; z_neg = 1 when Z_FLAGS_EN is defined.
- DIV 17/5: alu_c = {32'd2, 32'd3} → ZLO = 3, ZHI = 2, lo_q = 3, hi_q = 2.
- Back-pressure: hold bus_ready = 0 for 4 cycles during a MUL LO beat → bus_out is stable and in_ready = 0 throughout. Then beats complete in order.
- Back-to-back narrow: in_valid held with 3 AND results (32'hF0, 32'h0F, 32'h00), bus_ready = 1 → 3 beats on consecutive cycles. With Z_FLAGS_EN defined, z_zero = 1 only after the third.
- Reset: assert reset_n = 0 in the HI state of a DIV → bus_valid = 0 asynchronously and lo_q = hi_q = 0. After release, the next ADD is output normally.
